// File: rtl/clk_lock_reset_seq_pkg.sv
// Shared definitions for the clock-lock reset sequencer. SoC debug registers
// decode state_dbg with state_e.
package clk_lock_reset_seq_pkg;

  typedef enum logic [1:0] {
    StWaitLock = 2'd0,
    StStable   = 2'd1,
    StHold     = 2'd2,
    StRun      = 2'd3
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_lock_reset_seq_sync_ff.sv
// Multi-stage 1-bit synchronizer for asynchronous level inputs; flops clear to 0 on reset.
module clk_lock_reset_seq_sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clk_lock_reset_seq.sv
// Reset sequencer: synchronizes and qualifies CCC lock, then releases system reset after a
// programmable hold-off. Lock loss in RUN re-asserts reset and is counted (saturating).
module clk_lock_reset_seq
  import clk_lock_reset_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RESET_HOLD_CYCLES  = 64,
  parameter int unsigned LOSS_COUNT_WIDTH   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pll_lock,
  input  logic                        soft_reset_req,
  output logic                        sys_reset,
  output logic                        clk_ready,
  output logic [LOSS_COUNT_WIDTH-1:0] lock_loss_count,
  output logic [1:0]                  state_dbg
);

  localparam int unsigned CntMax   = max_u(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES);
  localparam int unsigned CntWidth = $clog2(CntMax + 1);

  localparam logic [CntWidth-1:0] StableLast = CntWidth'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CntWidth-1:0] HoldLast   = CntWidth'(RESET_HOLD_CYCLES - 1);

  logic                        lock_s;
  state_e                      state_q, state_d;
  logic [CntWidth-1:0]         cnt_q, cnt_d;
  logic [LOSS_COUNT_WIDTH-1:0] loss_q, loss_d;

  clk_lock_reset_seq_sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StWaitLock;
      cnt_q   <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      loss_q  <= loss_d;
    end
  end

  // Lock loss is checked first in every state so it beats both expiry and soft reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
    unique case (state_q)
      StWaitLock: begin
        cnt_d = '0;
        if (lock_s) state_d = StStable;
      end
      StStable: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == HoldLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d = StWaitLock;
          if (loss_q != '1) loss_d = loss_q + 1'b1;
        end else if (soft_reset_req) begin
          state_d = StHold;
        end
      end
      default: begin
        state_d = StWaitLock;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    sys_reset       = 1'b1;
    clk_ready       = 1'b0;
    lock_loss_count = loss_q;
    state_dbg       = state_q;
    if (state_q == StRun) begin
      sys_reset = 1'b0;
      clk_ready = 1'b1;
    end
  end

endmodule

// File: tb/tb_clk_lock_reset_seq.sv
// Directed bench for clk_lock_reset_seq with short qualification/hold-off counts.
module tb_clk_lock_reset_seq;

  logic       clk;
  logic       reset;
  logic       pll_lock;
  logic       soft_reset_req;
  logic       sys_reset;
  logic       clk_ready;
  logic [1:0] lock_loss_count;
  logic [1:0] state_dbg;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  clk_lock_reset_seq #(
    .SYNC_STAGES        (2),
    .LOCK_STABLE_CYCLES (16),
    .RESET_HOLD_CYCLES  (8),
    .LOSS_COUNT_WIDTH   (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pll_lock        (pll_lock),
    .soft_reset_req  (soft_reset_req),
    .sys_reset       (sys_reset),
    .clk_ready       (clk_ready),
    .lock_loss_count (lock_loss_count),
    .state_dbg       (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n edges; outputs are then sampled 1 time unit after the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
  endtask

  task automatic run_to(input int e);
    tick(e - edge_n);
  endtask

  // Reset, then release with pll_lock high so the next edge is edge 0.
  task automatic start_seq();
    reset = 1'b1;
    soft_reset_req = 1'b0;
    pll_lock = 1'b0;
    tick(2);
    reset = 1'b0;
    pll_lock = 1'b1;
    edge_n = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pll_lock = 1'b1;
    soft_reset_req = 1'b0;
    tick(3);
    checks++;
    if ({state_dbg, sys_reset, clk_ready, lock_loss_count} !== {2'd0, 1'b1, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_values: got st=%0d rst=%0b rdy=%0b cnt=%0d want st=0 rst=1 rdy=0 cnt=0",
               state_dbg, sys_reset, clk_ready, lock_loss_count);
    end
  endtask

  task automatic test_clean_start();
    start_seq();
    run_to(1);
    checks++;
    if (state_dbg !== 2'd0) begin
      errors++; $display("FAIL clean_e1_wait: got %0d want 0", state_dbg);
    end
    run_to(2);
    checks++;
    if (state_dbg !== 2'd1) begin
      errors++; $display("FAIL clean_e2_stable: got %0d want 1", state_dbg);
    end
    // soft_reset_req outside RUN must not disturb the timeline
    run_to(9);  soft_reset_req = 1'b1;
    run_to(10); soft_reset_req = 1'b0;
    run_to(17);
    checks++;
    if (state_dbg !== 2'd1) begin
      errors++; $display("FAIL clean_e17_stable: got %0d want 1", state_dbg);
    end
    run_to(18);
    checks++;
    if ({state_dbg, sys_reset} !== {2'd2, 1'b1}) begin
      errors++; $display("FAIL clean_e18_hold: got st=%0d rst=%0b want st=2 rst=1", state_dbg, sys_reset);
    end
    run_to(20); soft_reset_req = 1'b1;
    run_to(21); soft_reset_req = 1'b0;
    run_to(25);
    checks++;
    if ({state_dbg, sys_reset} !== {2'd2, 1'b1}) begin
      errors++; $display("FAIL clean_e25_hold: got st=%0d rst=%0b want st=2 rst=1", state_dbg, sys_reset);
    end
    run_to(26);
    checks++;
    if ({state_dbg, sys_reset, clk_ready} !== {2'd3, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL clean_e26_run: got st=%0d rst=%0b rdy=%0b want st=3 rst=0 rdy=1",
               state_dbg, sys_reset, clk_ready);
    end
  endtask

  task automatic test_glitch();
    start_seq();
    run_to(9);  pll_lock = 1'b0;
    run_to(10); pll_lock = 1'b1;
    run_to(11);
    checks++;
    if (state_dbg !== 2'd1) begin
      errors++; $display("FAIL glitch_e11_stable: got %0d want 1", state_dbg);
    end
    run_to(12);
    checks++;
    if (state_dbg !== 2'd0) begin
      errors++; $display("FAIL glitch_e12_wait: got %0d want 0", state_dbg);
    end
    run_to(13);
    checks++;
    if (state_dbg !== 2'd1) begin
      errors++; $display("FAIL glitch_e13_stable: got %0d want 1", state_dbg);
    end
    run_to(28);
    checks++;
    if (state_dbg !== 2'd1) begin
      errors++; $display("FAIL glitch_e28_stable: got %0d want 1", state_dbg);
    end
    run_to(29);
    checks++;
    if (state_dbg !== 2'd2) begin
      errors++; $display("FAIL glitch_e29_hold: got %0d want 2", state_dbg);
    end
    run_to(37);
    checks++;
    if ({state_dbg, lock_loss_count} !== {2'd3, 2'd0}) begin
      errors++;
      $display("FAIL glitch_e37_run: got st=%0d cnt=%0d want st=3 cnt=0", state_dbg, lock_loss_count);
    end
  endtask

  // Continues from test_clean_start (RUN at edge 26).
  task automatic test_lock_loss();
    run_to(39); pll_lock = 1'b0;
    run_to(41);
    checks++;
    if (state_dbg !== 2'd3) begin
      errors++; $display("FAIL loss_e41_run: got %0d want 3", state_dbg);
    end
    run_to(42);
    checks++;
    if ({state_dbg, sys_reset, clk_ready, lock_loss_count} !== {2'd0, 1'b1, 1'b0, 2'd1}) begin
      errors++;
      $display("FAIL loss_e42: got st=%0d rst=%0b rdy=%0b cnt=%0d want st=0 rst=1 rdy=0 cnt=1",
               state_dbg, sys_reset, clk_ready, lock_loss_count);
    end
    pll_lock = 1'b1;
    run_to(45);
    checks++;
    if (state_dbg !== 2'd1) begin
      errors++; $display("FAIL loss_e45_stable: got %0d want 1", state_dbg);
    end
    run_to(68);
    checks++;
    if (state_dbg !== 2'd2) begin
      errors++; $display("FAIL loss_e68_hold: got %0d want 2", state_dbg);
    end
    run_to(69);
    checks++;
    if ({state_dbg, sys_reset} !== {2'd3, 1'b0}) begin
      errors++; $display("FAIL loss_e69_run: got st=%0d rst=%0b want st=3 rst=0", state_dbg, sys_reset);
    end
  endtask

  // Continues from test_lock_loss (count 1, in RUN): three more losses -> 2, 3, 3.
  task automatic test_saturation();
    logic [1:0] exp_cnt [3];
    exp_cnt[0] = 2'd2; exp_cnt[1] = 2'd3; exp_cnt[2] = 2'd3;
    for (int i = 0; i < 3; i++) begin
      pll_lock = 1'b0;
      tick(3);
      checks++;
      if ({state_dbg, lock_loss_count} !== {2'd0, exp_cnt[i]}) begin
        errors++;
        $display("FAIL sat_loss%0d: got st=%0d cnt=%0d want st=0 cnt=%0d",
                 i, state_dbg, lock_loss_count, exp_cnt[i]);
      end
      pll_lock = 1'b1;
      tick(27);
      checks++;
      if (state_dbg !== 2'd3) begin
        errors++; $display("FAIL sat_rerun%0d: got %0d want 3", i, state_dbg);
      end
    end
    tick(5);
    checks++;
    if (lock_loss_count !== 2'd3) begin
      errors++; $display("FAIL sat_hold: got %0d want 3", lock_loss_count);
    end
  endtask

  task automatic test_soft_reset();
    start_seq();
    run_to(49); soft_reset_req = 1'b1;
    run_to(50); soft_reset_req = 1'b0;
    checks++;
    if ({state_dbg, sys_reset, clk_ready} !== {2'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL soft_e50: got st=%0d rst=%0b rdy=%0b want st=2 rst=1 rdy=0",
               state_dbg, sys_reset, clk_ready);
    end
    run_to(57);
    checks++;
    if (sys_reset !== 1'b1) begin
      errors++; $display("FAIL soft_e57_rst: got %0b want 1", sys_reset);
    end
    run_to(58);
    checks++;
    if ({state_dbg, sys_reset, clk_ready} !== {2'd3, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL soft_e58_run: got st=%0d rst=%0b rdy=%0b want st=3 rst=0 rdy=1",
               state_dbg, sys_reset, clk_ready);
    end
    // lock_s falls on the same edge soft_reset_req is sampled
    run_to(59); pll_lock = 1'b0;
    run_to(61); soft_reset_req = 1'b1;
    run_to(62); soft_reset_req = 1'b0;
    checks++;
    if ({state_dbg, sys_reset, lock_loss_count} !== {2'd0, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL soft_vs_loss: got st=%0d rst=%0b cnt=%0d want st=0 rst=1 cnt=1",
               state_dbg, sys_reset, lock_loss_count);
    end
  endtask

  task automatic test_reset_mid_hold();
    // Build a non-zero loss count, then reset while in HOLD.
    start_seq();
    run_to(26); pll_lock = 1'b0;
    run_to(28); pll_lock = 1'b1;
    run_to(55); soft_reset_req = 1'b1;
    run_to(56); soft_reset_req = 1'b0;
    checks++;
    if ({state_dbg, lock_loss_count} !== {2'd2, 2'd1}) begin
      errors++;
      $display("FAIL midhold_pre: got st=%0d cnt=%0d want st=2 cnt=1", state_dbg, lock_loss_count);
    end
    reset = 1'b1;
    run_to(57);
    checks++;
    if ({state_dbg, sys_reset, clk_ready, lock_loss_count} !== {2'd0, 1'b1, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL midhold_cnt_clear: got st=%0d rst=%0b rdy=%0b cnt=%0d want st=0 rst=1 rdy=0 cnt=0",
               state_dbg, sys_reset, clk_ready, lock_loss_count);
    end
    reset = 1'b0;
    edge_n = -1;
    run_to(20);
    checks++;
    if (state_dbg !== 2'd2) begin
      errors++; $display("FAIL midhold_e20: got %0d want 2", state_dbg);
    end
    reset = 1'b1;
    run_to(21);
    checks++;
    if ({state_dbg, sys_reset, clk_ready, lock_loss_count} !== {2'd0, 1'b1, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL midhold_e21: got st=%0d rst=%0b rdy=%0b cnt=%0d want st=0 rst=1 rdy=0 cnt=0",
               state_dbg, sys_reset, clk_ready, lock_loss_count);
    end
    reset = 1'b0;
    edge_n = -1;
    run_to(1);
    checks++;
    if (state_dbg !== 2'd0) begin
      errors++; $display("FAIL restart_e1: got %0d want 0", state_dbg);
    end
    run_to(2);
    checks++;
    if (state_dbg !== 2'd1) begin
      errors++; $display("FAIL restart_e2: got %0d want 1", state_dbg);
    end
    run_to(26);
    checks++;
    if ({state_dbg, clk_ready} !== {2'd3, 1'b1}) begin
      errors++; $display("FAIL restart_e26: got st=%0d rdy=%0b want st=3 rdy=1", state_dbg, clk_ready);
    end
  endtask

  initial begin
    reset = 1'b1;
    pll_lock = 1'b0;
    soft_reset_req = 1'b0;
    test_reset();
    test_clean_start();
    test_lock_loss();
    test_saturation();
    test_glitch();
    test_soft_reset();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
